// File: rtl/branch_resolve_unit_pkg.sv
// Shared rv32i types used by the branch resolution stage: branch condition
// encoding and the 2-bit branch history counter.
package rv32i_types;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } branch_funct3_t;

  typedef logic [1:0] bht_ctr_t;

  localparam bht_ctr_t BHT_RESET = 2'b01;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Request/response bundle between the execute operand muxes and the branch
// resolution stage; slave is the stage's view, master the producer/consumer view.
interface branch_resolve_unit_if #(
  parameter int WIDTH = 32
);
  import rv32i_types::*;

  logic             in_valid;
  logic             in_ready;
  branch_funct3_t   cmpop;
  logic [WIDTH-1:0] cmp_a;
  logic [WIDTH-1:0] cmp_b;
  logic [31:0]      pc;
  logic [31:0]      target;
  logic             pred_taken;

  logic             out_valid;
  logic             out_ready;
  logic             br_en;
  logic             mispredict;
  logic             illegal;
  logic [31:0]      redirect_pc;

  modport master (
    output in_valid, cmpop, cmp_a, cmp_b, pc, target, pred_taken, out_ready,
    input  in_ready, out_valid, br_en, mispredict, illegal, redirect_pc
  );

  modport slave (
    input  in_valid, cmpop, cmp_a, cmp_b, pc, target, pred_taken, out_ready,
    output in_ready, out_valid, br_en, mispredict, illegal, redirect_pc
  );

endinterface

// File: rtl/branch_resolve_unit_bht.sv
// Flat array of 2-bit saturating branch history counters with one
// combinational read port and one registered update port (no bypass).
module bht
  import rv32i_types::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic                     rd_taken,
  input  logic                     upd_en,
  input  logic [$clog2(DEPTH)-1:0] upd_idx,
  input  logic                     upd_taken
);

  bht_ctr_t ctr_q [DEPTH];
  bht_ctr_t ctr_d [DEPTH];

  always_comb begin
    ctr_d = ctr_q;
    if (upd_en) begin
      if (upd_taken && ctr_q[upd_idx] != 2'b11) begin
        ctr_d[upd_idx] = ctr_q[upd_idx] + 2'd1;
      end else if (!upd_taken && ctr_q[upd_idx] != 2'b00) begin
        ctr_d[upd_idx] = ctr_q[upd_idx] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctr_q[i] <= BHT_RESET;
      end
    end else begin
      ctr_q <= ctr_d;
    end
  end

  assign rd_taken = ctr_q[rd_idx][1];

endmodule

// File: rtl/branch_resolve_unit.sv
// Registered branch resolution stage: condition compare, redirect PC, mispredict
// flag and BHT training. Optional performance counters under `BR_STATS_EN.
module branch_resolve_unit
  import rv32i_types::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  branch_resolve_unit_if.slave        bus,
  input  logic [31:0]                 lookup_pc,
  output logic                        lookup_taken,
  output logic [31:0]                 stat_branches,
  output logic [31:0]                 stat_mispredicts
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cond_taken;
  logic             cond_illegal;
  logic             in_ready;
  logic             capture;
  logic             accept;

  logic        out_valid_q, out_valid_d;
  logic        br_en_q, br_en_d;
  logic        mispredict_q, mispredict_d;
  logic        illegal_q, illegal_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [31:0] pc_q, pc_d;

  assign op_a = bus.cmp_a;
  assign op_b = bus.cmp_b;

  always_comb begin
    cond_taken   = 1'b0;
    cond_illegal = 1'b0;
    case (bus.cmpop)
      BR_BEQ:  cond_taken = (op_a == op_b);
      BR_BNE:  cond_taken = (op_a != op_b);
      BR_BLT:  cond_taken = ($signed(op_a) < $signed(op_b));
      BR_BGE:  cond_taken = ($signed(op_a) >= $signed(op_b));
      BR_BLTU: cond_taken = (op_a < op_b);
      BR_BGEU: cond_taken = (op_a >= op_b);
      default: cond_illegal = 1'b1;
    endcase
  end

  assign in_ready = !out_valid_q || bus.out_ready;
  assign capture  = bus.in_valid && in_ready && !flush;
  assign accept   = out_valid_q && bus.out_ready && !flush;

  // Flush wins over a same-cycle capture; otherwise an accepted result empties the slot.
  always_comb begin
    out_valid_d   = out_valid_q;
    br_en_d       = br_en_q;
    mispredict_d  = mispredict_q;
    illegal_d     = illegal_q;
    redirect_pc_d = redirect_pc_q;
    pc_d          = pc_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (capture) begin
      out_valid_d   = 1'b1;
      br_en_d       = cond_taken;
      mispredict_d  = cond_taken != bus.pred_taken;
      illegal_d     = cond_illegal;
      redirect_pc_d = cond_taken ? bus.target : bus.pc + 32'd4;
      pc_d          = bus.pc;
    end else if (accept) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      br_en_q       <= 1'b0;
      mispredict_q  <= 1'b0;
      illegal_q     <= 1'b0;
      redirect_pc_q <= 32'd0;
      pc_q          <= 32'd0;
    end else begin
      out_valid_q   <= out_valid_d;
      br_en_q       <= br_en_d;
      mispredict_q  <= mispredict_d;
      illegal_q     <= illegal_d;
      redirect_pc_q <= redirect_pc_d;
      pc_q          <= pc_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.br_en       = br_en_q;
  assign bus.mispredict  = mispredict_q;
  assign bus.illegal     = illegal_q;
  assign bus.redirect_pc = redirect_pc_q;

  bht #(.DEPTH(DEPTH)) u_bht (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (lookup_pc[IDX_W+1:2]),
    .rd_taken  (lookup_taken),
    .upd_en    (accept && !illegal_q),
    .upd_idx   (pc_q[IDX_W+1:2]),
    .upd_taken (br_en_q)
  );

  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc, pc_q};

`ifdef BR_STATS_EN
  logic [31:0] stat_branches_q, stat_branches_d;
  logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

  // Illegal results count as branches but never as mispredicts.
  always_comb begin
    stat_branches_d    = stat_branches_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (accept) begin
      stat_branches_d = stat_branches_q + 32'd1;
      if (mispredict_q && !illegal_q) begin
        stat_mispredicts_d = stat_mispredicts_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches_q    <= 32'd0;
      stat_mispredicts_q <= 32'd0;
    end else begin
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;
`else
  assign stat_branches    = 32'd0;
  assign stat_mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: vector table for the comparator and
// redirect path, hand sequences for backpressure, flush, BHT training and stats.
module tb_branch_resolve_unit;
  import rv32i_types::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [31:0] lookup_pc;
  logic        lookup_taken;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  int vec_count   = 0;
  int miscompares = 0;

`ifdef BR_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  branch_resolve_unit_if #(.WIDTH(32)) bus ();

  branch_resolve_unit #(.WIDTH(32), .DEPTH(64)) dut (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .bus              (bus),
    .lookup_pc        (lookup_pc),
    .lookup_taken     (lookup_taken),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        pred;
    logic        exp_br;
    logic        exp_mis;
    logic        exp_ill;
    logic [31:0] exp_redir;
  } vec_t;

  vec_t vecs [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [2:0] op,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] pc, input logic [31:0] tgt,
                               input logic pred);
    bus.in_valid   = valid;
    bus.cmpop      = branch_funct3_t'(op);
    bus.cmp_a      = a;
    bus.cmp_b      = b;
    bus.pc         = pc;
    bus.target     = tgt;
    bus.pred_taken = pred;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] result_word();
    return {28'd0, bus.out_valid, bus.br_en, bus.mispredict, bus.illegal, bus.redirect_pc};
  endfunction

  function automatic logic [63:0] expect_word(input logic v, input logic br, input logic mis,
                                              input logic ill, input logic [31:0] redir);
    return {28'd0, v, br, mis, ill, redir};
  endfunction

  initial begin
    vecs[0]  = '{3'b100, 32'hFFFF_FFFF, 32'h1,         32'h204,       32'h300,       1'b0, 1'b1, 1'b1, 1'b0, 32'h300};
    vecs[1]  = '{3'b110, 32'hFFFF_FFFF, 32'h1,         32'h208,       32'hDEAD_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h20C};
    vecs[2]  = '{3'b101, 32'hFFFF_FFFF, 32'h1,         32'h20C,       32'hDEAD_0000, 1'b1, 1'b0, 1'b1, 1'b0, 32'h210};
    vecs[3]  = '{3'b111, 32'hFFFF_FFFF, 32'h1,         32'h210,       32'h400,       1'b1, 1'b1, 1'b0, 1'b0, 32'h400};
    vecs[4]  = '{3'b000, 32'h5,         32'h5,         32'h214,       32'h500,       1'b1, 1'b1, 1'b0, 1'b0, 32'h500};
    vecs[5]  = '{3'b001, 32'h5,         32'h5,         32'h218,       32'hDEAD_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h21C};
    vecs[6]  = '{3'b000, 32'h5,         32'h6,         32'h21C,       32'hDEAD_0000, 1'b1, 1'b0, 1'b1, 1'b0, 32'h220};
    vecs[7]  = '{3'b001, 32'h5,         32'h6,         32'h220,       32'h600,       1'b0, 1'b1, 1'b1, 1'b0, 32'h600};
    vecs[8]  = '{3'b100, 32'h8000_0000, 32'h7FFF_FFFF, 32'h224,       32'h700,       1'b1, 1'b1, 1'b0, 1'b0, 32'h700};
    vecs[9]  = '{3'b110, 32'h8000_0000, 32'h7FFF_FFFF, 32'h228,       32'hDEAD_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h22C};
    vecs[10] = '{3'b010, 32'h0,         32'h0,         32'hFFFF_FFFC, 32'h800,       1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
    vecs[11] = '{3'b011, 32'h7,         32'h7,         32'h230,       32'h800,       1'b0, 1'b0, 1'b0, 1'b1, 32'h234};

    rst           = 1'b1;
    flush         = 1'b0;
    lookup_pc     = 32'h100;
    bus.out_ready = 1'b1;
    applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    tick();
    tick();
    checkOutput("reset_result", result_word(), expect_word(1'b0, 1'b0, 1'b0, 1'b0, 32'h0));
    checkOutput("reset_in_ready", {63'd0, bus.in_ready}, 64'd1);
    checkOutput("reset_lookup", {63'd0, lookup_taken}, 64'd0);
    checkOutput("reset_stats", {stat_branches, stat_mispredicts}, 64'd0);
    rst = 1'b0;

    // Table: one request per cycle, each result checked one cycle after capture.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].pc, vecs[i].tgt, vecs[i].pred);
      tick();
      checkOutput($sformatf("vec%0d", i), result_word(),
                  expect_word(1'b1, vecs[i].exp_br, vecs[i].exp_mis, vecs[i].exp_ill, vecs[i].exp_redir));
    end
    applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    tick();
    checkOutput("drain_valid", {63'd0, bus.out_valid}, 64'd0);

    // Backpressure: hold A for three cycles while B waits.
    bus.out_ready = 1'b0;
    applyStimulus(1'b1, 3'b000, 32'h1, 32'h1, 32'h240, 32'h900, 1'b1);
    tick();
    checkOutput("bp_capture", result_word(), expect_word(1'b1, 1'b1, 1'b0, 1'b0, 32'h900));
    applyStimulus(1'b1, 3'b001, 32'h1, 32'h2, 32'h244, 32'hA00, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("bp_in_ready%0d", k), {63'd0, bus.in_ready}, 64'd0);
      tick();
      checkOutput($sformatf("bp_hold%0d", k), result_word(), expect_word(1'b1, 1'b1, 1'b0, 1'b0, 32'h900));
    end
    bus.out_ready = 1'b1;
    #1;
    checkOutput("bp_release_ready", {63'd0, bus.in_ready}, 64'd1);
    tick();
    checkOutput("bp_next", result_word(), expect_word(1'b1, 1'b1, 1'b1, 1'b0, 32'hA00));

    // Flush with result held and a new request offered: both disappear.
    bus.out_ready = 1'b0;
    lookup_pc     = 32'h244;
    applyStimulus(1'b1, 3'b000, 32'h0, 32'h0, 32'h100, 32'hB00, 1'b0);
    flush = 1'b1;
    tick();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    checkOutput("flush_clear", {63'd0, bus.out_valid}, 64'd0);
    tick();
    checkOutput("flush_drop", {63'd0, bus.out_valid}, 64'd0);
    checkOutput("flush_no_train", {63'd0, lookup_taken}, 64'd0);

    // Flush while the consumer is ready must not train or count.
    bus.out_ready = 1'b1;
    applyStimulus(1'b1, 3'b000, 32'h3, 32'h3, 32'h244, 32'hB00, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    flush        = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("flush_ready_clear", {63'd0, bus.out_valid}, 64'd0);
    checkOutput("flush_ready_no_train", {63'd0, lookup_taken}, 64'd0);
    checkOutput("stats_after_flush", {stat_branches, stat_mispredicts},
                STATS_ON ? {32'd13, 32'd4} : 64'd0);

    // BHT training on pc 0x100: three taken, then two not taken.
    lookup_pc = 32'h100;
    #1;
    checkOutput("bht_init", {63'd0, lookup_taken}, 64'd0);
    applyStimulus(1'b1, 3'b000, 32'h0, 32'h0, 32'h100, 32'hC00, 1'b0);
    tick();
    checkOutput("bht_t0", {63'd0, lookup_taken}, 64'd0);
    tick();
    checkOutput("bht_t1", {63'd0, lookup_taken}, 64'd1);
    tick();
    checkOutput("bht_t2", {63'd0, lookup_taken}, 64'd1);
    bus.in_valid = 1'b0;
    tick();
    checkOutput("bht_t3_sat", {63'd0, lookup_taken}, 64'd1);
    applyStimulus(1'b1, 3'b001, 32'h0, 32'h0, 32'h100, 32'hC00, 1'b0);
    tick();
    tick();
    checkOutput("bht_nt1", {63'd0, lookup_taken}, 64'd1);
    bus.in_valid = 1'b0;
    tick();
    checkOutput("bht_nt2", {63'd0, lookup_taken}, 64'd0);
    checkOutput("stats_total", {stat_branches, stat_mispredicts},
                STATS_ON ? {32'd18, 32'd7} : 64'd0);

    // Reset with a live result and a trained entry.
    lookup_pc = 32'h204;
    #1;
    checkOutput("pre_reset_lookup", {63'd0, lookup_taken}, 64'd1);
    bus.out_ready = 1'b0;
    applyStimulus(1'b1, 3'b000, 32'h0, 32'h0, 32'h300, 32'hD00, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    checkOutput("pre_reset_valid", result_word(), expect_word(1'b1, 1'b1, 1'b1, 1'b0, 32'hD00));
    rst   = 1'b1;
    flush = 1'b1;
    tick();
    rst   = 1'b0;
    flush = 1'b0;
    checkOutput("reset2_result", result_word(), expect_word(1'b0, 1'b0, 1'b0, 1'b0, 32'h0));
    checkOutput("reset2_bht", {63'd0, lookup_taken}, 64'd0);
    checkOutput("reset2_stats", {stat_branches, stat_mispredicts}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
